sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Datapath-priority arbiter granting a 4-phase host port access to line-buffer SRAM banks.
// Optional host starvation timeout is built when ARB_HOST_TIMEOUT_EN is defined.
module sram_port_arbiter #(
    parameter int SRAM_SIZE      = 18,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dp_active_i,
    input  logic [SRAM_SIZE-1:0]            dp_rden_i,
    input  logic [SRAM_SIZE-1:0]            dp_wren_i,
    input  logic [ADDR_WIDTH-1:0]           dp_addr_i,
    input  logic [DATA_WIDTH-1:0]           dp_wdata_i,
    input  logic                            host_req_i,
    input  logic                            host_we_i,
    input  logic [4:0]                      host_bank_i,
    input  logic [ADDR_WIDTH-1:0]           host_addr_i,
    input  logic [DATA_WIDTH-1:0]           host_wdata_i,
    output logic                            host_ack_o,
    output logic                            host_err_o,
    output logic [DATA_WIDTH-1:0]           host_rdata_o,
    output logic [SRAM_SIZE-1:0]            sram_rden_o,
    output logic [SRAM_SIZE-1:0]            sram_wren_o,
    output logic [ADDR_WIDTH-1:0]           sram_addr_o,
    output logic [DATA_WIDTH-1:0]           sram_wdata_o,
    input  logic [SRAM_SIZE*DATA_WIDTH-1:0] sram_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_e;

    state_e                  state_q, state_d;
    logic [4:0]              bank_q, bank_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    host_grant;
    logic                    bank_bad;
    logic                    tmo_hit;
    logic [SRAM_SIZE-1:0]    bank_sel;
    logic [DATA_WIDTH-1:0]   bank_rdata;

    assign bank_bad   = int'(host_bank_i) >= SRAM_SIZE;
    assign host_grant = (state_q == ACCESS) && !dp_active_i;

    always_comb begin
        bank_sel   = '0;
        bank_rdata = '0;
        for (int b = 0; b < SRAM_SIZE; b++) begin
            if (int'(bank_q) == b) begin
                bank_sel[b] = 1'b1;
                bank_rdata  = sram_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Zero-latency mux: the datapath sees the array untouched unless the host holds the grant.
    always_comb begin
        sram_rden_o  = dp_rden_i;
        sram_wren_o  = dp_wren_i;
        sram_addr_o  = dp_addr_i;
        sram_wdata_o = dp_wdata_i;
        if (host_grant) begin
            sram_rden_o  = we_q ? '0 : bank_sel;
            sram_wren_o  = we_q ? bank_sel : '0;
            sram_addr_o  = addr_q;
            sram_wdata_o = wdata_q;
        end
    end

`ifdef ARB_HOST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_q, tmo_d;
    logic          starving;

    assign starving = (state_q == IDLE) && host_req_i && dp_active_i;
    assign tmo_hit  = starving && (tmo_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = '0;
        if (starving) tmo_d = tmo_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (host_req_i) begin
                    if (bank_bad || tmo_hit) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (!dp_active_i) begin
                        state_d = ACCESS;
                        bank_d  = host_bank_i;
                        addr_d  = host_addr_i;
                        we_d    = host_we_i;
                        wdata_d = host_wdata_i;
                    end
                end
            end
            ACCESS:  state_d = dp_active_i ? IDLE : CAPTURE;
            CAPTURE: begin
                rdata_d = we_q ? '0 : bank_rdata;
                state_d = DONE;
            end
            DONE: begin
                if (!host_req_i) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign host_ack_o   = (state_q == DONE);
    assign host_err_o   = err_q;
    assign host_rdata_o = rdata_q;

endmodule
